// File: rtl/pqc_decode_pkg.sv
// Shared types and defaults for the code-to-float decode path (unpacker and decoder).
package pqc_decode_pkg;

    localparam int unsigned DEF_WORD_WIDTH  = 32;
    localparam int unsigned DEF_CODE_WIDTH  = 8;
    localparam int unsigned DEF_COUNT_WIDTH = 16;
    localparam int unsigned MAX_CODE_VALUE  = 12;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        WAIT,
        DONE
    } unpack_state_t;

    // Slot index width; a single-code word still needs one bit.
    function automatic int unsigned slot_width(input int unsigned codes_per_word);
        return (codes_per_word > 1) ? $clog2(codes_per_word) : 1;
    endfunction

endpackage

// File: rtl/code_word_shifter.sv
// Holds one packed word and presents the code in slot `sel`.
// While `load` is high the incoming word is presented, so the caller can register slot 0 on the transfer edge.
module code_word_shifter
    import pqc_decode_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int unsigned CODE_WIDTH = DEF_CODE_WIDTH,
    parameter int unsigned SLOT_WIDTH = slot_width(WORD_WIDTH / CODE_WIDTH)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load,
    input  logic [WORD_WIDTH-1:0] word_in,
    input  logic [SLOT_WIDTH-1:0] sel,
    output logic [CODE_WIDTH-1:0] code_c
);

    localparam int unsigned CODES_PER_WORD = WORD_WIDTH / CODE_WIDTH;

    logic [WORD_WIDTH-1:0] word_q;
    logic [WORD_WIDTH-1:0] word_view;
    logic [CODE_WIDTH-1:0] slots [CODES_PER_WORD];

    always_ff @(posedge clock) begin
        if (reset) begin
            word_q <= '0;
        end else if (load) begin
            word_q <= word_in;
        end
    end

    assign word_view = load ? word_in : word_q;

    for (genvar i = 0; i < CODES_PER_WORD; i++) begin : g_slot
        assign slots[i] = word_view[CODE_WIDTH*i +: CODE_WIDTH];
    end

    assign code_c = slots[sel];

endmodule

// File: rtl/code_unpacker.sv
// Splits packed code words LSB-first and hands codes one at a time to the decoder.
// Optional CODE_RANGE_CHECK_EN builds the sticky out-of-range code detector behind range_err.
module code_unpacker
    import pqc_decode_pkg::*;
#(
    parameter int unsigned WORD_WIDTH  = DEF_WORD_WIDTH,
    parameter int unsigned CODE_WIDTH  = DEF_CODE_WIDTH,
    parameter int unsigned COUNT_WIDTH = DEF_COUNT_WIDTH
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [COUNT_WIDTH-1:0] num_codes,
    input  logic                   word_valid,
    input  logic [WORD_WIDTH-1:0]  word_data,
    output logic                   word_ready,
    output logic                   decode_start,
    output logic [CODE_WIDTH-1:0]  out_code,
    input  logic                   data_ready,
    output logic                   busy,
    output logic                   done,
    output logic                   range_err
);

    localparam int unsigned CODES_PER_WORD = WORD_WIDTH / CODE_WIDTH;
    localparam int unsigned SLOT_WIDTH     = slot_width(CODES_PER_WORD);
    localparam logic [SLOT_WIDTH-1:0] LAST_SLOT = SLOT_WIDTH'(CODES_PER_WORD - 1);

    unpack_state_t          state;
    logic [COUNT_WIDTH-1:0] remaining;
    logic [SLOT_WIDTH-1:0]  slot;
    logic [SLOT_WIDTH-1:0]  sel_c;
    logic                   load_c;
    logic [CODE_WIDTH-1:0]  code_c;

    // From WAIT the next issue uses the following slot; elsewhere the current one.
    assign sel_c  = (state == WAIT) ? slot + SLOT_WIDTH'(1) : slot;
    assign load_c = (state == FETCH) && word_valid && word_ready;

    code_word_shifter #(
        .WORD_WIDTH (WORD_WIDTH),
        .CODE_WIDTH (CODE_WIDTH),
        .SLOT_WIDTH (SLOT_WIDTH)
    ) u_shifter (
        .clock   (clock),
        .reset   (reset),
        .load    (load_c),
        .word_in (word_data),
        .sel     (sel_c),
        .code_c  (code_c)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            remaining    <= '0;
            slot         <= '0;
            word_ready   <= 1'b0;
            decode_start <= 1'b0;
            out_code     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            decode_start <= 1'b0;
            done         <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        remaining <= num_codes;
                        slot      <= '0;
                        busy      <= 1'b1;
                        if (num_codes == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state      <= FETCH;
                            word_ready <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (word_valid) begin
                        word_ready   <= 1'b0;
                        out_code     <= code_c;
                        decode_start <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (data_ready) begin
                        remaining <= remaining - COUNT_WIDTH'(1);
                        if (remaining == COUNT_WIDTH'(1)) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else if (slot == LAST_SLOT) begin
                            slot       <= '0;
                            word_ready <= 1'b1;
                            state      <= FETCH;
                        end else begin
                            slot         <= slot + SLOT_WIDTH'(1);
                            out_code     <= code_c;
                            decode_start <= 1'b1;
                            state        <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef CODE_RANGE_CHECK_EN
    // The decoder ignores the top two bits, so only the low field is range checked.
    always_ff @(posedge clock) begin
        if (reset) begin
            range_err <= 1'b0;
        end else if ((state == IDLE) && start) begin
            range_err <= 1'b0;
        end else if ((state == ISSUE) &&
                     (out_code[CODE_WIDTH-3:0] > (CODE_WIDTH-2)'(MAX_CODE_VALUE))) begin
            range_err <= 1'b1;
        end
    end
`else
    assign range_err = 1'b0;
`endif

endmodule

// File: tb/tb_code_unpacker.sv
// Self-checking bench for code_unpacker: frame table, scoreboard of expected codes, decoder model.
module tb_code_unpacker;

    localparam int unsigned WW   = 32;
    localparam int unsigned CW   = 8;
    localparam int unsigned CNTW = 16;
    localparam int unsigned CPW  = WW / CW;

    logic            clock = 1'b0;
    logic            reset;
    logic            start;
    logic [CNTW-1:0] num_codes;
    logic            word_valid;
    logic [WW-1:0]   word_data;
    logic            word_ready;
    logic            decode_start;
    logic [CW-1:0]   out_code;
    logic            data_ready;
    logic            busy;
    logic            done;
    logic            range_err;

    int n_tests = 0;
    int n_fail  = 0;
    int dr_cd   = 0;

    typedef struct {
        int          n;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w2;
        int          gap;
        bit          poke;
        int          exp_xfers;
        bit          exp_err;
    } frame_vec_t;

    frame_vec_t vecs [9];

    code_unpacker #(
        .WORD_WIDTH  (WW),
        .CODE_WIDTH  (CW),
        .COUNT_WIDTH (CNTW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .num_codes    (num_codes),
        .word_valid   (word_valid),
        .word_data    (word_data),
        .word_ready   (word_ready),
        .decode_start (decode_start),
        .out_code     (out_code),
        .data_ready   (data_ready),
        .busy         (busy),
        .done         (done),
        .range_err    (range_err)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic flag_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Decoder: data_ready pulses two cycles after a decode_start cycle.
    task automatic dec_model();
        data_ready = 1'b0;
        if (dr_cd > 0) begin
            dr_cd--;
            if (dr_cd == 0) data_ready = 1'b1;
        end
        if (decode_start) dr_cd = 2;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_word_ready"},   word_ready,   0);
        check({tag, "_decode_start"}, decode_start, 0);
        check({tag, "_out_code"},     out_code,     0);
        check({tag, "_busy"},         busy,         0);
        check({tag, "_done"},         done,         0);
        check({tag, "_range_err"},    range_err,    0);
    endtask

    task automatic run_frame(input frame_vec_t v);
        logic [WW-1:0] wq [3];
        logic [CW-1:0] exp_q [$];
        logic [WW-1:0] w;
        logic [CW-1:0] code;
        logic [CW-1:0] held;
        bit  exp_err, got_done, holding, want_ready, prev_wr;
        int  widx, xfers, rises, gap_cnt, xfer_cyc, prev_ds, last_dr, ds_in_word;

        wq[0] = v.w0;
        wq[1] = v.w1;
        wq[2] = v.w2;
        for (int i = 0; i < v.n; i++) begin
            w    = wq[i / CPW];
            code = w[CW*(i % CPW) +: CW];
            exp_q.push_back(code);
        end
`ifdef CODE_RANGE_CHECK_EN
        exp_err = v.exp_err;
`else
        exp_err = 1'b0;
`endif

        start      = 1'b1;
        num_codes  = CNTW'(v.n);
        data_ready = 1'b0;
        word_valid = 1'b0;
        dr_cd      = 0;
        step();

        widx = 0; xfers = 0; rises = 0; gap_cnt = 0;
        xfer_cyc = -10; prev_ds = -10; last_dr = -1; ds_in_word = 0;
        holding = 0; got_done = 0; prev_wr = 0; want_ready = 0;
        for (int cyc = 0; cyc < 400 && !got_done; cyc++) begin
            start = 1'b0;
            if (cyc == 0) check("range_err_cleared_on_start", range_err, 0);
            check("busy_in_frame", busy, 1);
            if (want_ready) check("ready_held_under_backpressure", word_ready, 1);
            if (word_ready && !prev_wr) rises++;
            prev_wr = word_ready;
            if (decode_start) begin
                if (exp_q.size() == 0) flag_fail("unexpected_issue");
                else check("out_code", out_code, exp_q.pop_front());
                if (ds_in_word == 0) check("first_issue_latency", cyc - xfer_cyc, 1);
                else check("issue_cadence", cyc - prev_ds, 3);
                ds_in_word++;
                prev_ds = cyc;
                held    = out_code;
                holding = 1;
                if (v.poke) begin
                    start     = 1'b1;
                    num_codes = CNTW'(7);
                end
            end else if (holding) begin
                check("out_code_stable", out_code, held);
            end
            if (done) begin
                got_done = 1;
                check("done_latency", cyc - last_dr, 1);
                check("range_err_at_done", range_err, exp_err);
            end

            dec_model();
            if (data_ready) begin
                last_dr = cyc;
                holding = 0;
            end
            want_ready = 0;
            word_valid = 1'b0;
            if (word_ready) begin
                if (gap_cnt < v.gap) begin
                    gap_cnt++;
                    want_ready = 1;
                end else begin
                    word_valid = 1'b1;
                    word_data  = (widx < 3) ? wq[widx] : '0;
                    widx++;
                    xfers++;
                    xfer_cyc   = cyc;
                    ds_in_word = 0;
                    gap_cnt    = 0;
                end
            end
            step();
        end
        start      = 1'b0;
        word_valid = 1'b0;
        data_ready = 1'b0;

        if (!got_done) flag_fail("frame_timeout");
        check("codes_outstanding", exp_q.size(), 0);
        check("word_transfers", xfers, v.exp_xfers);
        check("word_ready_assertions", rises, v.exp_xfers);
        check("busy_after_done", busy, 0);
        check("done_single_pulse", done, 0);
        check("range_err_sticky", range_err, exp_err);

        // Stray data_ready while idle must do nothing.
        data_ready = 1'b1;
        step();
        data_ready = 1'b0;
        check("idle_dr_decode_start", decode_start, 0);
        check("idle_dr_word_ready", word_ready, 0);
        check("idle_dr_busy", busy, 0);
        dr_cd = 0;
    endtask

    initial begin
        int  ds_seen;
        bit  hit;
        frame_vec_t v1;

        //            n  w0            w1            w2            gap poke xfers err
        vecs[0] = '{4, 32'h0C030201, 32'h0,        32'h0,        0, 1'b0, 1, 1'b0};
        vecs[1] = '{5, 32'h04030201, 32'h08070605, 32'h0,        0, 1'b0, 2, 1'b0};
        vecs[2] = '{0, 32'h0,        32'h0,        32'h0,        0, 1'b0, 0, 1'b0};
        vecs[3] = '{4, 32'h44332211, 32'h0,        32'h0,        5, 1'b0, 1, 1'b1};
        vecs[4] = '{4, 32'h0C0B0D01, 32'h0,        32'h0,        0, 1'b0, 1, 1'b1};
        vecs[5] = '{4, 32'hC0C14C8C, 32'h0,        32'h0,        0, 1'b0, 1, 1'b0};
        vecs[6] = '{9, 32'h0A090807, 32'h06050403, 32'h00000C0B, 2, 1'b1, 3, 1'b0};
        vecs[7] = '{8, 32'h01020304, 32'h3F000000, 32'h0,        0, 1'b0, 2, 1'b1};
        vecs[8] = '{0, 32'h0,        32'h0,        32'h0,        0, 1'b0, 0, 1'b0};

        reset      = 1'b1;
        start      = 1'b0;
        num_codes  = '0;
        word_valid = 1'b0;
        word_data  = '0;
        data_ready = 1'b0;
        repeat (3) step();
        check_idle_outputs("reset");
        reset = 1'b0;
        step();
        check_idle_outputs("post_reset");

        for (int i = 0; i < 9; i++) run_frame(vecs[i]);

        // Reset in WAIT after the second code.
        start     = 1'b1;
        num_codes = CNTW'(4);
        dr_cd     = 0;
        step();
        start   = 1'b0;
        ds_seen = 0;
        hit     = 0;
        for (int cyc = 0; cyc < 100 && !hit; cyc++) begin
            if (decode_start) ds_seen++;
            dec_model();
            word_valid = word_ready;
            word_data  = 32'h0C030201;
            if (ds_seen == 2 && !decode_start) begin
                hit        = 1;
                reset      = 1'b1;
                data_ready = 1'b0;
                word_valid = 1'b0;
            end
            step();
        end
        if (!hit) flag_fail("reset_seq_timeout");
        check_idle_outputs("mid_frame_reset");
        reset      = 1'b0;
        data_ready = 1'b1;
        step();
        data_ready = 1'b0;
        check("late_dr_decode_start", decode_start, 0);
        check("late_dr_busy", busy, 0);
        check("late_dr_word_ready", word_ready, 0);
        dr_cd = 0;

        v1 = '{1, 32'hAABBCC07, 32'h0, 32'h0, 0, 1'b0, 1, 1'b0};
        run_frame(v1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
